// File: rtl/ik_swift_avalon_bridge.sv
// Avalon-MM slave that loads ik_swift operands, runs one fixed-latency solve and captures delta.
// Optional interrupt output: define IK_SWIFT_BRIDGE_IRQ_EN.
//
// state | meaning
// IDLE  | waiting for a start command
// CLR   | one-cycle ik_rst pulse to the core
// RUN   | ik_en high while the down-counter runs LATENCY..1
// CAP   | delta latched into capture regs, done set
module ik_swift_avalon_bridge #(
  parameter int unsigned LATENCY = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    chipselect,
  input  logic                    write,
  input  logic                    read,
  input  logic [6:0]              address,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic                    ik_en,
  output logic                    ik_rst,
  output logic [2:0][35:0]        z,
  output logic [5:0]              joint_type,
  output logic [5:0][3:0][35:0]   dh_param,
  output logic [5:0][35:0]        target,
  input  logic [5:0][35:0]        delta
`ifdef IK_SWIFT_BRIDGE_IRQ_EN
  ,
  output logic                    irq
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_CAP} state_t;
  localparam int unsigned NWORDS = 33;

  state_t            state, state_n;
  logic [15:0]       cnt;
  logic [35:0]       opr [NWORDS];
  logic [5:0]        jt;
  logic [5:0][35:0]  cap;
  logic              done, done_n, irq_en, irq_en_n;
  logic              wr, rd, ctrl_wr, start_req, clear_req, ack_req, busy;
  logic [5:0]        op_idx;
  logic [2:0]        cap_idx;
  logic [35:0]       op_word, cap_word;
  logic [31:0]       rdata;

  assign wr        = chipselect & write;
  assign rd        = chipselect & read;
  assign ctrl_wr   = wr & (address == 7'd67);
  assign clear_req = ctrl_wr & writedata[1];
  assign start_req = ctrl_wr & writedata[0] & ~writedata[1];  // clear beats start
  assign busy      = (state != S_IDLE);

`ifdef IK_SWIFT_BRIDGE_IRQ_EN
  assign ack_req  = ctrl_wr & writedata[2];
  assign irq_en_n = ctrl_wr ? writedata[3] : irq_en;
`else
  assign ack_req  = 1'b0;
  assign irq_en_n = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start_req) state_n = S_CLR;
      S_CLR:   state_n = S_RUN;
      S_RUN:   if (cnt == 16'd1) state_n = S_CAP;
      S_CAP:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (clear_req) state_n = S_IDLE;
  end

  always_comb begin
    done_n = done;
    if (state == S_CAP) done_n = 1'b1;
    if (start_req && !busy) done_n = 1'b0;
    if (clear_req || ack_req) done_n = 1'b0;
  end

  // ik_en/ik_rst are registered from the next state so they line up with CLR/RUN exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      irq_en <= 1'b0;
      ik_en  <= 1'b0;
      ik_rst <= 1'b1;
      cap    <= '0;
    end else begin
      state  <= state_n;
      done   <= done_n;
      irq_en <= irq_en_n;
      ik_en  <= (state_n == S_RUN);
      ik_rst <= (state_n == S_CLR);
      if (state == S_RUN) cnt <= cnt - 16'd1;
      else                cnt <= LATENCY[15:0];
      if (clear_req)           cap <= '0;
      else if (state == S_CAP) cap <= delta;
    end
  end

`ifdef IK_SWIFT_BRIDGE_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= done_n & irq_en_n;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NWORDS; k++) opr[k] <= '0;
      jt <= '0;
    end else if (wr && !busy) begin
      if (address < 7'd66) begin
        if (address[0]) opr[address[6:1]][35:32] <= writedata[3:0];
        else            opr[address[6:1]][31:0]  <= writedata;
      end else if (address == 7'd66) begin
        jt <= writedata[5:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) z[i] = opr[i];
    for (int j = 0; j < 6; j++) begin
      target[j] = opr[27 + j];
      for (int p = 0; p < 4; p++) dh_param[j][p] = opr[3 + 4 * j + p];
    end
    joint_type = jt;
  end

  always_comb begin
    op_idx   = (address < 7'd66) ? address[6:1] : 6'd0;
    cap_idx  = (address >= 7'd68 && address < 7'd80) ? 3'(address[6:1] - 6'd34) : 3'd0;
    op_word  = opr[op_idx];
    cap_word = cap[cap_idx];
    rdata    = '0;
    if (address < 7'd66)
      rdata = address[0] ? {{28{op_word[35]}}, op_word[35:32]} : op_word[31:0];
    else if (address == 7'd66)
      rdata = {26'd0, jt};
    else if (address == 7'd67)
      rdata = {28'd0, irq_en, 1'b0, done, busy};
    else if (address < 7'd80)
      rdata = address[0] ? {{28{cap_word[35]}}, cap_word[35:32]} : cap_word[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     readdata <= '0;
    else if (rd) readdata <= rdata;
  end

endmodule

// File: tb/tb_ik_swift_avalon_bridge.sv
// Directed bench for ik_swift_avalon_bridge: register map vectors plus solve sequencing cases.
module tb_ik_swift_avalon_bridge;
  localparam int LAT = 12;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  chipselect = 1'b0;
  logic                  write = 1'b0;
  logic                  read = 1'b0;
  logic [6:0]            address = '0;
  logic [31:0]           writedata = '0;
  logic [31:0]           readdata;
  logic                  ik_en, ik_rst;
  logic [2:0][35:0]      z;
  logic [5:0]            joint_type;
  logic [5:0][3:0][35:0] dh_param;
  logic [5:0][35:0]      target;
  logic [5:0][35:0]      delta = '0;
`ifdef IK_SWIFT_BRIDGE_IRQ_EN
  logic                  irq;
`endif

  ik_swift_avalon_bridge #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .ik_en(ik_en), .ik_rst(ik_rst), .z(z), .joint_type(joint_type),
    .dh_param(dh_param), .target(target), .delta(delta)
`ifdef IK_SWIFT_BRIDGE_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: delta[i] counts (i+1) per enabled cycle, delta[5] mirrors target[5]
  always @(posedge clk) begin
    if (ik_rst) delta <= '0;
    else if (ik_en) begin
      for (int i = 0; i < 5; i++) delta[i] <= delta[i] + 36'(i + 1);
      delta[5] <= target[5];
    end
  end

  int   en_cnt = 0, rst_cnt = 0, rise_cyc = -1;
  logic en_prev = 1'b0;
  always @(negedge clk) begin
    if (ik_en) en_cnt <= en_cnt + 1;
    if (ik_rst && !rst) rst_cnt <= rst_cnt + 1;
    if (ik_en && !en_prev) rise_cyc <= cyc;
    en_prev <= ik_en;
  end

  typedef struct {
    bit          is_wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus tasks are entered at a negedge and return at the following negedge
  task automatic bus_wr(input logic [6:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [6:0] a, output logic [31:0] d, output int sc);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a; sc = cyc;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; d = readdata;
  endtask

  task automatic rd_chk(input string name, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int sc;
    bus_rd(a, d, sc);
    chk(name, 64'(d), 64'(exp));
  endtask

  // Returns the cycle (1 = cycle after the start write) in which done was first seen, -1 on timeout
  task automatic poll_done(input int w, output int rel);
    logic [31:0] d;
    int sc;
    rel = -1;
    for (int i = 0; i < 4 * LAT + 40 && rel < 0; i++) begin
      bus_rd(7'd67, d, sc);
      if (d[1]) rel = sc - w + 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, rel, e0, r0;

    vecs.push_back('{1'b1, 7'd0,   32'h0000_0001, 32'h0});
    vecs.push_back('{1'b1, 7'd1,   32'h0000_000F, 32'h0});
    vecs.push_back('{1'b0, 7'd1,   32'h0,         32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 7'd0,   32'h0,         32'h0000_0001});
    vecs.push_back('{1'b1, 7'd2,   32'hDEAD_BEEF, 32'h0});
    vecs.push_back('{1'b1, 7'd3,   32'h0000_0007, 32'h0});
    vecs.push_back('{1'b0, 7'd2,   32'h0,         32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 7'd3,   32'h0,         32'h0000_0007});
    vecs.push_back('{1'b1, 7'd66,  32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, 7'd66,  32'h0,         32'h0000_003F});
    vecs.push_back('{1'b1, 7'd20,  32'hA5A5_A5A5, 32'h0});
    vecs.push_back('{1'b1, 7'd21,  32'h0000_0001, 32'h0});
    vecs.push_back('{1'b0, 7'd21,  32'h0,         32'h0000_0001});
    vecs.push_back('{1'b0, 7'd20,  32'h0,         32'hA5A5_A5A5});
    vecs.push_back('{1'b1, 7'd64,  32'h0000_0003, 32'h0});
    vecs.push_back('{1'b1, 7'd65,  32'h0000_0008, 32'h0});
    vecs.push_back('{1'b0, 7'd65,  32'h0,         32'hFFFF_FFF8});
    vecs.push_back('{1'b0, 7'd64,  32'h0,         32'h0000_0003});
    vecs.push_back('{1'b1, 7'd100, 32'h0000_1234, 32'h0});
    vecs.push_back('{1'b0, 7'd100, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 7'd127, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 7'd67,  32'h0,         32'h0});
    vecs.push_back('{1'b0, 7'd68,  32'h0,         32'h0});

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_readdata", 64'(readdata), 64'(0));
    chk("rst_ik_en", 64'(ik_en), 64'(0));
    chk("rst_ik_rst", 64'(ik_rst), 64'(1));
    chk("rst_z0", 64'(z[0]), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("ik_rst_release", 64'(ik_rst), 64'(0));

    // register map
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) bus_wr(vecs[i].addr, vecs[i].data);
      else rd_chk($sformatf("vec%0d_addr%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end
    chk("z0_out", 64'(z[0]), 64'(36'hF_0000_0001));
    chk("z1_out", 64'(z[1]), 64'(36'h7_DEAD_BEEF));
    chk("dh13_out", 64'(dh_param[1][3]), 64'(36'h1_A5A5_A5A5));
    chk("target5_out", 64'(target[5]), 64'(36'h8_0000_0003));
    chk("joint_type_out", 64'(joint_type), 64'(6'h3F));

    // solve timing and capture
    e0 = en_cnt; r0 = rst_cnt;
    bus_wr(7'd67, 32'h1); w = cyc;
    chk("clr_pulse", 64'(ik_rst), 64'(1));
    chk("en_low_in_clr", 64'(ik_en), 64'(0));
    rd_chk("status_busy", 7'd67, 32'h1);
    poll_done(w, rel);
    chk("done_latency", 64'(rel), 64'(LAT + 3));
    chk("en_first_cycle", 64'(rise_cyc - w + 1), 64'(2));
    chk("en_cycles", 64'(en_cnt - e0), 64'(LAT));
    chk("rst_pulses", 64'(rst_cnt - r0), 64'(1));
    rd_chk("status_done", 7'd67, 32'h2);
    rd_chk("delta0_lo", 7'd68, 32'(LAT));
    rd_chk("delta1_lo", 7'd70, 32'(2 * LAT));
    rd_chk("delta4_hi", 7'd77, 32'h0);
    rd_chk("delta5_lo", 7'd78, 32'h0000_0003);
    rd_chk("delta5_hi", 7'd79, 32'hFFFF_FFF8);
`ifndef IK_SWIFT_BRIDGE_IRQ_EN
    bus_wr(7'd67, 32'hC);
    rd_chk("ack_ignored", 7'd67, 32'h2);
`endif

    // writes and start while busy
    e0 = en_cnt; r0 = rst_cnt;
    bus_wr(7'd67, 32'h1); w = cyc;
    bus_wr(7'd20, 32'h0);
    bus_wr(7'd67, 32'h1);
    bus_wr(7'd66, 32'h0);
    poll_done(w, rel);
    chk("no_restart_latency", 64'(rel), 64'(LAT + 3));
    chk("no_restart_en", 64'(en_cnt - e0), 64'(LAT));
    chk("no_restart_rst", 64'(rst_cnt - r0), 64'(1));
    rd_chk("busy_write_ignored", 7'd20, 32'hA5A5_A5A5);
    chk("busy_jt_ignored", 64'(joint_type), 64'(6'h3F));

    // clear during RUN cycle 10
    e0 = en_cnt;
    bus_wr(7'd67, 32'h1); w = cyc;
    repeat (10) @(negedge clk);
    chk("en_before_clear", 64'(ik_en), 64'(1));
    bus_wr(7'd67, 32'h2);
    chk("en_after_clear", 64'(ik_en), 64'(0));
    rd_chk("status_after_clear", 7'd67, 32'h0);
    chk("en_cycles_clear", 64'(en_cnt - e0), 64'(10));
    rd_chk("delta0_cleared", 7'd68, 32'h0);
    rd_chk("delta5_cleared", 7'd78, 32'h0);
    rd_chk("operand_kept", 7'd0, 32'h0000_0001);
    chk("z0_kept", 64'(z[0]), 64'(36'hF_0000_0001));

    // start and clear together
    e0 = en_cnt; r0 = rst_cnt;
    bus_wr(7'd67, 32'h3);
    repeat (3) @(negedge clk);
    rd_chk("start_clear_status", 7'd67, 32'h0);
    chk("start_clear_rst", 64'(rst_cnt - r0), 64'(0));
    chk("start_clear_en", 64'(en_cnt - e0), 64'(0));

`ifdef IK_SWIFT_BRIDGE_IRQ_EN
    chk("irq_idle", 64'(irq), 64'(0));
    bus_wr(7'd67, 32'h8);
    bus_wr(7'd67, 32'h9); w = cyc;
    poll_done(w, rel);
    chk("irq_done_latency", 64'(rel), 64'(LAT + 3));
    chk("irq_high", 64'(irq), 64'(1));
    rd_chk("irq_status", 7'd67, 32'hA);
    bus_wr(7'd67, 32'h4);
    chk("irq_ack", 64'(irq), 64'(0));
    rd_chk("irq_ack_status", 7'd67, 32'h0);
`endif

    // asynchronous reset mid-solve
    bus_wr(7'd67, 32'h1);
    repeat (4) @(negedge clk);
    chk("en_before_reset", 64'(ik_en), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("reset_abort_en", 64'(ik_en), 64'(0));
    chk("reset_abort_rst", 64'(ik_rst), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rst_drop", 64'(ik_rst), 64'(0));
    rd_chk("reset_status", 7'd67, 32'h0);
    rd_chk("reset_operand", 7'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
